// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the unified memory.
// slave is the arbiter's view; master is the environment (core + memory) view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output if_rdata, if_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises the core's fetch and data ports onto one single-port memory with
// data priority, a fetch anti-starvation streak limit and a per-transfer watchdog.
module mem_port_arbiter #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          if_elig, d_elig;
    logic          grant_f, grant_d, done, tmo;
    logic [31:0]   ret_data;

    logic          m_req_q, m_we_q, if_ack_q, d_ack_q, err_q;
    logic [31:0]   m_addr_q, m_wdata_q, if_rdata_q, d_rdata_q;

    // A port being acknowledged this cycle is masked from arbitration.
    assign if_elig = bus.if_req & ~if_ack_q;
    assign d_elig  = bus.d_req  & ~d_ack_q;

    // Next-state, grant and transfer-completion decode.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        grant_f  = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        ret_data = '0;
        case (state_q)
            IDLE: begin
                if (d_elig && (!if_elig || streak_q != STREAK_MAX)) begin
                    state_d  = DATA;
                    grant_d  = 1'b1;
                    timer_d  = '0;
                    if (if_elig) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_elig) begin
                    state_d  = FETCH;
                    grant_f  = 1'b1;
                    timer_d  = '0;
                    streak_d = '0;
                end
            end
            FETCH, DATA: begin
                timer_d = timer_q + TW'(1);
                if (bus.m_ready) begin
                    done     = 1'b1;
                    ret_data = bus.m_rdata;
                    state_d  = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, command capture and completion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            timer_q    <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            m_req_q  <= (state_d != IDLE);
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            if (grant_d) begin
                m_addr_q  <= bus.d_addr;
                m_we_q    <= bus.d_we;
                m_wdata_q <= bus.d_wdata;
            end else if (grant_f) begin
                m_addr_q  <= bus.if_addr;
                m_we_q    <= 1'b0;
                m_wdata_q <= '0;
            end
            if (done || tmo) begin
                err_q <= tmo;
                if (state_q == FETCH) begin
                    if_ack_q   <= 1'b1;
                    if_rdata_q <= ret_data;
                end else begin
                    d_ack_q <= 1'b1;
                    // Stores leave the load data register untouched.
                    if (!m_we_q) begin
                        d_rdata_q <= ret_data;
                    end
                end
            end
        end
    end

    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.if_ack   = if_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.err      = err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.stall    = if_elig | d_elig;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, priority, wait states,
// store hold, watchdog timeout, streak limit and reset during a transfer.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_STREAK(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          cnt;
        int          ngrant;
        logic [9:0]  order;
        logic        prev_mreq;
        logic        exp_stall;

        n_cmp = 0;
        n_err = 0;

        // Reset with random inputs
        reset        = 1'b1;
        bus.if_req   = 1'($urandom);
        bus.if_addr  = $urandom;
        bus.d_req    = 1'($urandom);
        bus.d_we     = 1'($urandom);
        bus.d_addr   = $urandom;
        bus.d_wdata  = $urandom;
        bus.m_rdata  = $urandom;
        bus.m_ready  = 1'($urandom);
        repeat (3) step();
        exp_stall = bus.if_req | bus.d_req;
        chk("rst_m_req",    32'(bus.m_req),   32'd0);
        chk("rst_m_we",     32'(bus.m_we),    32'd0);
        chk("rst_m_addr",   bus.m_addr,       32'd0);
        chk("rst_m_wdata",  bus.m_wdata,      32'd0);
        chk("rst_if_ack",   32'(bus.if_ack),  32'd0);
        chk("rst_d_ack",    32'(bus.d_ack),   32'd0);
        chk("rst_err",      32'(bus.err),     32'd0);
        chk("rst_if_rdata", bus.if_rdata,     32'd0);
        chk("rst_d_rdata",  bus.d_rdata,      32'd0);
        chk("rst_stall",    32'(bus.stall),   32'(exp_stall));

        // Release reset; memory responses in IDLE must be ignored
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h5A5A_5A5A;
        reset       = 1'b0;
        step();
        step();
        chk("post_rst_m_req",   32'(bus.m_req),  32'd0);
        chk("post_rst_d_ack",   32'(bus.d_ack),  32'd0);
        chk("post_rst_if_rdat", bus.if_rdata,    32'd0);
        chk("post_rst_stall",   32'(bus.stall),  32'd0);

        // Single fetch, zero wait states
        bus.m_ready = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        step();
        chk("sf_m_req",  32'(bus.m_req), 32'd1);
        chk("sf_m_addr", bus.m_addr,     32'h0000_0100);
        chk("sf_m_we",   32'(bus.m_we),  32'd0);
        chk("sf_if_ack0", 32'(bus.if_ack), 32'd0);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hE3A0_0005;
        step();
        chk("sf_if_ack",   32'(bus.if_ack), 32'd1);
        chk("sf_if_rdata", bus.if_rdata,    32'hE3A0_0005);
        chk("sf_err",      32'(bus.err),    32'd0);
        chk("sf_stall",    32'(bus.stall),  32'd0);
        chk("sf_m_req_lo", 32'(bus.m_req),  32'd0);
        bus.if_req  = 1'b0;
        bus.m_ready = 1'b0;
        step();
        chk("sf_if_ack_pulse", 32'(bus.if_ack), 32'd0);

        // Simultaneous store and fetch: data first, fetch granted in the d_ack cycle
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_2000;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0104;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hAAAA_5555;
        step();
        chk("sim_m_addr",  bus.m_addr,    32'h0000_2000);
        chk("sim_m_we",    32'(bus.m_we), 32'd1);
        chk("sim_m_wdata", bus.m_wdata,   32'hDEAD_BEEF);
        step();
        chk("sim_d_ack",    32'(bus.d_ack),  32'd1);
        chk("sim_if_ack0",  32'(bus.if_ack), 32'd0);
        chk("sim_d_rdata",  bus.d_rdata,     32'd0);
        bus.d_req   = 1'b0;
        bus.m_rdata = 32'hE1A0_0000;
        step();
        chk("sim_f_m_addr",  bus.m_addr,     32'h0000_0104);
        chk("sim_f_m_we",    32'(bus.m_we),  32'd0);
        chk("sim_f_m_wdata", bus.m_wdata,    32'd0);
        chk("sim_d_ack_lo",  32'(bus.d_ack), 32'd0);
        step();
        chk("sim_if_ack",   32'(bus.if_ack), 32'd1);
        chk("sim_if_rdata", bus.if_rdata,    32'hE1A0_0000);
        bus.if_req  = 1'b0;
        bus.m_ready = 1'b0;
        step();

        // Load with one wait state
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_2004;
        step();
        chk("ld_m_addr", bus.m_addr,    32'h0000_2004);
        chk("ld_m_we",   32'(bus.m_we), 32'd0);
        step();
        chk("ld_wait_m_req", 32'(bus.m_req), 32'd1);
        chk("ld_wait_d_ack", 32'(bus.d_ack), 32'd0);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h1234_5678;
        step();
        chk("ld_d_ack",   32'(bus.d_ack), 32'd1);
        chk("ld_d_rdata", bus.d_rdata,    32'h1234_5678);
        bus.d_req   = 1'b0;
        bus.m_ready = 1'b0;
        step();

        // Store must not disturb the load data register
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_2008;
        bus.d_wdata = 32'h0000_0001;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
        step();
        step();
        chk("st_d_ack",    32'(bus.d_ack), 32'd1);
        chk("st_d_rdata",  bus.d_rdata,    32'h1234_5678);
        bus.d_req   = 1'b0;
        bus.m_ready = 1'b0;
        step();

        // Watchdog timeout on a load
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_3000;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (bus.m_req) cnt++;
            if (bus.d_ack) break;
        end
        chk("to_m_req_cycles", 32'(cnt),        32'd16);
        chk("to_d_ack",        32'(bus.d_ack),  32'd1);
        chk("to_err",          32'(bus.err),    32'd1);
        chk("to_d_rdata",      bus.d_rdata,     32'd0);
        chk("to_m_req_lo",     32'(bus.m_req),  32'd0);
        bus.d_req = 1'b0;
        step();
        chk("to_err_pulse", 32'(bus.err),   32'd0);
        chk("to_idle",      32'(bus.m_req), 32'd0);

        // Streak limit. In every ack cycle the other port's request is withdrawn
        // for that one cycle, so each grant is decided with both ports eligible.
        bus.if_addr = 32'h0000_0500;
        bus.d_addr  = 32'h0000_0600;
        bus.d_we    = 1'b0;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'd0;
        ngrant    = 0;
        order     = '0;
        prev_mreq = 1'b0;
        for (int k = 0; k < 80 && ngrant < 10; k++) begin
            if (bus.m_req && !prev_mreq) begin
                order = {order[8:0], (bus.m_addr == 32'h0000_0600)};
                ngrant++;
            end
            prev_mreq = bus.m_req;
            if (bus.d_ack) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b1;
            end else if (bus.if_ack) begin
                bus.if_req = 1'b1;
                bus.d_req  = 1'b0;
            end else begin
                bus.if_req = 1'b1;
                bus.d_req  = 1'b1;
            end
            step();
        end
        chk("starve_grants", 32'(ngrant), 32'd10);
        chk("starve_order",  32'(order),  32'(10'b11110_11110));
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) step();

        // Reset in the second wait cycle of a store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_4000;
        bus.d_wdata = 32'hCAFE_F00D;
        step();
        chk("rmt_m_req_w1", 32'(bus.m_req), 32'd1);
        step();
        chk("rmt_m_req_w2", 32'(bus.m_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmt_m_req_async", 32'(bus.m_req), 32'd0);
        bus.d_req = 1'b0;
        step();
        chk("rmt_m_addr", bus.m_addr, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.d_ack || bus.m_req) cnt++;
        end
        chk("rmt_no_ack", 32'(cnt), 32'd0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0000_0BAD;
        step();
        chk("rmt_next_m_addr", bus.m_addr, 32'h0000_0200);
        step();
        chk("rmt_next_if_ack",   32'(bus.if_ack), 32'd1);
        chk("rmt_next_if_rdata", bus.if_rdata,    32'h0000_0BAD);
        bus.if_req  = 1'b0;
        bus.m_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
